fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer that drives the program counter's jump, target and stall inputs.
- Arbitrates between exception entry, taken branches from execute, load-use hazards from decode, and instruction-memory wait states.
- Generates pipeline flush and bubble controls.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- DBITS, 32, datapath/address width
- EXC_VECTOR, 32'h40, exception handler address driven on PC_TARGET
- BOOT_CYCLES, 4, PC hold cycles after reset release (1..15)
- HAZ_CYCLES, 1, stall cycles per load-use hazard (1..3)
- IMEM_TIMEOUT, 255, max consecutive IMWAIT cycles before ERR (8-bit)

Ports:
- CLK  in  1  clock
- RESETN  in  1  asynchronous active-low reset
- BR_TAKEN  in  1  execute stage resolved a taken branch/jump
- BR_TARGET  in  DBITS  branch destination, valid with BR_TAKEN
- EXC  in  1  exception request, single-cycle pulse
- LD_USE_HAZ  in  1  decode detected load-use dependency
- IMEM_VALID  in  1  instruction memory returned valid word this cycle
- CNT_CLR  in  1  synchronous clear of STALL_CNT
- PC_JMP  out  1  load PC from PC_TARGET
- PC_TARGET  out  DBITS  redirect address
- PC_STALL  out  1  hold PC
- FLUSH_IF  out  1  squash IF/ID register
- FLUSH_ID  out  1  squash ID/EX register
- BUBBLE_EX  out  1  insert nop into execute
- STALL_CNT  out  16  cycles with PC_STALL=1, saturating
- ERR  out  1  sticky imem timeout flag
- STATE  out  3  current FSM state (debug)

Behaviour:
- States: BOOT=0, RUN=1, HAZ=2, IMWAIT=3, REDIRECT=4. State register only; outputs are Mealy, combinational from state and inputs.
- Reset (RESETN=0, async):
  - state=BOOT, counters=0, ERR=0, STALL_CNT=0.
  - Outputs during reset: PC_STALL=1; PC_JMP, FLUSH_IF, FLUSH_ID, BUBBLE_EX=0; PC_TARGET=0.
  - Reset asserted mid-operation aborts any state and returns to BOOT.
- Input priority, applied in every state except BOOT: EXC > BR_TAKEN > LD_USE_HAZ > !IMEM_VALID.
- BOOT:
  - PC_STALL=1, all inputs ignored.
  - Counts BOOT_CYCLES rising edges after reset release, then enters RUN.
- Redirect actions, taken when EXC or BR_TAKEN is honoured in any state other than BOOT:
  - EXC: PC_JMP=1, PC_TARGET=EXC_VECTOR, FLUSH_IF=1, FLUSH_ID=1; next=REDIRECT.
  - BR_TAKEN: PC_JMP=1, PC_TARGET=BR_TARGET, FLUSH_IF=1, FLUSH_ID=1; next=REDIRECT.
  - PC_STALL=0 in both cases.
  - Any in-progress hazard or wait counter is cleared.
- RUN:
  - LD_USE_HAZ: PC_STALL=1, BUBBLE_EX=1; if HAZ_CYCLES>1, next=HAZ with count=1.
  - !IMEM_VALID: PC_STALL=1, FLUSH_IF=1; next=IMWAIT, wait count=1.
  - Otherwise all controls 0.
- HAZ:
  - PC_STALL=1, BUBBLE_EX=1.
  - Returns to RUN once HAZ_CYCLES total stall cycles have elapsed.
  - LD_USE_HAZ is not re-sampled while in HAZ.
- IMWAIT:
  - PC_STALL=1, FLUSH_IF=1 while IMEM_VALID=0; wait count increments, saturating at 255.
  - When the count reaches IMEM_TIMEOUT, ERR sets and stays set until reset; the FSM keeps waiting.
  - IMEM_VALID=1: outputs 0 that cycle, next=RUN.
- REDIRECT:
  - One cycle, FLUSH_IF=1 (squashes the wrong-path fetch).
  - BR_TAKEN and LD_USE_HAZ are ignored (wrong-path sources).
  - EXC is honoured as a new redirect.
  - Otherwise next=RUN.
- STALL_CNT:
  - Increments on each clock edge where PC_STALL=1 and state≠BOOT.
  - Saturates at 16'hFFFF.
  - CNT_CLR wins over increment.
- Widths: PC_TARGET passes BR_TARGET through unmodified; no alignment check.

Test Plan:
- Reset, then release → PC_STALL=1 for 4 cycles, STATE=0→1 on the 4th edge, STALL_CNT=0.
- RUN, BR_TAKEN=1 with BR_TARGET=32'h100 →
  - same cycle: PC_JMP=1, PC_TARGET=32'h100, FLUSH_IF=FLUSH_ID=1;
  - next cycle: REDIRECT with FLUSH_IF=1, BR_TAKEN ignored;
  - following cycle: RUN.
- RUN, EXC and BR_TAKEN in the same cycle → PC_TARGET=32'h40; same test with HAZ_CYCLES=2 and LD_USE_HAZ=1 simultaneously → no BUBBLE_EX.
- HAZ_CYCLES=2, LD_USE_HAZ pulsed 1 cycle → PC_STALL=BUBBLE_EX=1 for exactly 2 cycles, STALL_CNT=2.
- IMEM_VALID=0 for 300 cycles, IMEM_TIMEOUT=255 → ERR rises at wait cycle 255 and stays 1 after IMEM_VALID returns; STALL_CNT=300.
- STALL_CNT preloaded near FFFF via long stall → holds at FFFF; CNT_CLR=1 → 0. RESETN dropped mid-IMWAIT → STATE=0 immediately, ERR=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer arbitrating exceptions, branches, load-use hazards and imem waits.
module fetch_ctrl #(
  parameter int               DBITS        = 32,
  parameter logic [DBITS-1:0] EXC_VECTOR   = 'h40,
  parameter int               BOOT_CYCLES  = 4,
  parameter int               HAZ_CYCLES   = 1,
  parameter int               IMEM_TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             BR_TAKEN,
  input  logic [DBITS-1:0] BR_TARGET,
  input  logic             EXC,
  input  logic             LD_USE_HAZ,
  input  logic             IMEM_VALID,
  input  logic             CNT_CLR,
  output logic             PC_JMP,
  output logic [DBITS-1:0] PC_TARGET,
  output logic             PC_STALL,
  output logic             FLUSH_IF,
  output logic             FLUSH_ID,
  output logic             BUBBLE_EX,
  output logic [15:0]      STALL_CNT,
  output logic             ERR,
  output logic [2:0]       STATE
);
  typedef enum logic [2:0] {BOOT = 3'd0, RUN = 3'd1, HAZ = 3'd2, IMWAIT = 3'd3, REDIRECT = 3'd4} state_t;
  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);
  localparam logic [7:0] HAZ_LAST  = 8'(HAZ_CYCLES - 1);
  localparam logic [7:0] TIMEOUT   = 8'(IMEM_TIMEOUT);
  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       err_set, redirect;
  assign STATE = state;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= BOOT;
      cnt       <= '0;
      ERR       <= 1'b0;
      STALL_CNT <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ERR       <= ERR | err_set;
      STALL_CNT <= CNT_CLR ? '0 : (PC_STALL && state != BOOT && STALL_CNT != 16'hFFFF) ? STALL_CNT + 16'd1 : STALL_CNT;
    end
  end
  // One shared counter: boot cycles, hazard cycles, or consecutive imem wait cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    PC_JMP    = 1'b0;
    PC_TARGET = '0;
    PC_STALL  = 1'b0;
    FLUSH_IF  = 1'b0;
    FLUSH_ID  = 1'b0;
    BUBBLE_EX = 1'b0;
    err_set   = 1'b0;
    redirect  = state != BOOT && (EXC || (BR_TAKEN && state != REDIRECT));
    if (state == BOOT) begin
      PC_STALL  = 1'b1;
      state_nxt = cnt == BOOT_LAST ? RUN : BOOT;
      cnt_nxt   = cnt == BOOT_LAST ? 8'd0 : cnt + 8'd1;
    end else if (redirect) begin
      PC_JMP    = 1'b1;
      PC_TARGET = EXC ? EXC_VECTOR : BR_TARGET;
      FLUSH_IF  = 1'b1;
      FLUSH_ID  = 1'b1;
      state_nxt = REDIRECT;
      cnt_nxt   = '0;
    end else if (state == REDIRECT) begin
      FLUSH_IF  = 1'b1;
      state_nxt = RUN;
    end else if (state == HAZ) begin
      PC_STALL  = 1'b1;
      BUBBLE_EX = 1'b1;
      state_nxt = cnt >= HAZ_LAST ? RUN : HAZ;
      cnt_nxt   = cnt >= HAZ_LAST ? 8'd0 : cnt + 8'd1;
    end else if (LD_USE_HAZ) begin
      PC_STALL  = 1'b1;
      BUBBLE_EX = 1'b1;
      state_nxt = HAZ_CYCLES > 1 ? HAZ : RUN;
      cnt_nxt   = HAZ_CYCLES > 1 ? 8'd1 : 8'd0;
    end else if (!IMEM_VALID) begin
      PC_STALL  = 1'b1;
      FLUSH_IF  = 1'b1;
      state_nxt = IMWAIT;
      cnt_nxt   = state != IMWAIT ? 8'd1 : cnt == 8'hFF ? cnt : cnt + 8'd1;
      err_set   = cnt_nxt == TIMEOUT;
    end else begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end
  end
endmodule
